// File: rtl/fnd_source_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fnd_source_scheduler_pkg
// Brief    : Shared source/page/state encodings and time-field bundle for the
//            FND source scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package fnd_source_scheduler_pkg;

  localparam logic SRC_SW  = 1'b0;
  localparam logic SRC_WT  = 1'b1;
  localparam logic PAGE_MS = 1'b0;
  localparam logic PAGE_MH = 1'b1;

  typedef enum logic [0:0] {
    ST_SEL = 1'b0,
    ST_OVR = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic [6:0] msec;
    logic [6:0] sec;
    logic [6:0] min;
    logic [6:0] hour;
  } time_fields_t;

endpackage : fnd_source_scheduler_pkg
`default_nettype wire

// File: rtl/fnd_page_timer.sv
`default_nettype none
// ============================================================================
// Module   : fnd_page_timer
// Brief    : Tick counter with clear/enable; pulses o_wrap on the tick that
//            completes PAGE_TICKS periods.
// Revision : 1.0 - initial release
// ============================================================================
module fnd_page_timer #(
  parameter int PAGE_TICKS = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_wrap
);

  localparam int              CW     = $clog2(PAGE_TICKS);
  localparam logic [CW-1:0]   C_LAST = CW'(PAGE_TICKS - 1);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  assign o_wrap = i_enable && i_tick && (r_cnt == C_LAST);

  // Disabled counter sits at zero so re-enabling starts a full period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear || !i_enable || o_wrap) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

endmodule : fnd_page_timer
`default_nettype wire

// File: rtl/fnd_source_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fnd_source_scheduler
// Brief    : Selects stopwatch or watch time for the FND controller, with page
//            control, auto scroll and timed UART display overrides.
// Revision : 1.0 - initial release
// ============================================================================
module fnd_source_scheduler
  import fnd_source_scheduler_pkg::*;
#(
  parameter int HOLD_TICKS = 300,
  parameter int PAGE_TICKS = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_btn_src,
  input  logic       i_btn_page,
  input  logic       i_auto_en,
  input  logic       i_req_valid,
  input  logic       i_req_src,
  output logic       o_req_ready,
  input  logic [6:0] i_sw_msec,
  input  logic [6:0] i_sw_sec,
  input  logic [6:0] i_sw_min,
  input  logic [6:0] i_sw_hour,
  input  logic       i_sw_upd,
  input  logic [6:0] i_wt_msec,
  input  logic [6:0] i_wt_sec,
  input  logic [6:0] i_wt_min,
  input  logic [6:0] i_wt_hour,
  input  logic       i_wt_upd,
  output logic [6:0] o_msec,
  output logic [6:0] o_sec,
  output logic [6:0] o_min,
  output logic [6:0] o_hour,
  output logic       o_time_mode,
  output logic       o_src,
  output logic       o_override
);

  localparam int            HW          = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] C_HOLD_LOAD = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] C_HOLD_ONE  = HW'(1);

  sched_state_t  r_state,     w_state_nxt;
  logic          r_base_src,  w_base_src_nxt;
  logic          r_ovr_src,   w_ovr_src_nxt;
  logic [HW-1:0] r_hold_cnt,  w_hold_cnt_nxt;
  logic          r_req_ready;
  logic          r_override;
  logic          r_src,       w_src_nxt;
  logic          r_time_mode, w_time_mode_nxt;
  time_fields_t  r_fields;

  time_fields_t  w_sw_fields, w_wt_fields, w_new_fields;
  logic          w_new_upd;
  logic          w_src_change;
  logic          w_page_wrap;

  assign w_sw_fields = '{msec: i_sw_msec, sec: i_sw_sec, min: i_sw_min, hour: i_sw_hour};
  assign w_wt_fields = '{msec: i_wt_msec, sec: i_wt_sec, min: i_wt_min, hour: i_wt_hour};

  always_comb begin
    w_state_nxt    = r_state;
    w_ovr_src_nxt  = r_ovr_src;
    w_hold_cnt_nxt = r_hold_cnt;
    w_base_src_nxt = r_base_src ^ i_btn_src;
    case (r_state)
      ST_SEL: begin
        if (i_req_valid && r_req_ready) begin
          w_state_nxt    = ST_OVR;
          w_ovr_src_nxt  = i_req_src;
          w_hold_cnt_nxt = C_HOLD_LOAD;
        end
      end
      ST_OVR: begin
        if (i_tick) begin
          w_hold_cnt_nxt = r_hold_cnt - C_HOLD_ONE;
          if (r_hold_cnt == C_HOLD_ONE) begin
            w_state_nxt = ST_SEL;
          end
        end
      end
      default: w_state_nxt = ST_SEL;
    endcase

    // A base-source press during an override only shows once the override ends.
    w_src_nxt    = (w_state_nxt == ST_OVR) ? w_ovr_src_nxt : w_base_src_nxt;
    w_src_change = (w_src_nxt != r_src);
    w_new_fields = (w_src_nxt == SRC_WT) ? w_wt_fields : w_sw_fields;
    w_new_upd    = (w_src_nxt == SRC_WT) ? i_wt_upd : i_sw_upd;

    if (w_src_change) begin
      w_time_mode_nxt = PAGE_MS;
    end else begin
      w_time_mode_nxt = r_time_mode ^ (i_btn_page | w_page_wrap);
    end
  end

  fnd_page_timer #(
    .PAGE_TICKS (PAGE_TICKS)
  ) u_page_timer (
    .clk      (clk),
    .reset    (reset),
    .i_tick   (i_tick),
    .i_enable (i_auto_en),
    .i_clear  (w_src_change | i_btn_page),
    .o_wrap   (w_page_wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SEL;
      r_base_src  <= SRC_SW;
      r_ovr_src   <= SRC_SW;
      r_hold_cnt  <= '0;
      r_req_ready <= 1'b0;
      r_override  <= 1'b0;
      r_src       <= SRC_SW;
      r_time_mode <= PAGE_MS;
      r_fields    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_base_src  <= w_base_src_nxt;
      r_ovr_src   <= w_ovr_src_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_req_ready <= (w_state_nxt == ST_SEL);
      r_override  <= (w_state_nxt == ST_OVR);
      r_src       <= w_src_nxt;
      r_time_mode <= w_time_mode_nxt;
      // All four fields load together so the display never mixes two samples.
      if (w_src_change || w_new_upd) begin
        r_fields <= w_new_fields;
      end
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_override  = r_override;
  assign o_src       = r_src;
  assign o_time_mode = r_time_mode;
  assign o_msec      = r_fields.msec;
  assign o_sec       = r_fields.sec;
  assign o_min       = r_fields.min;
  assign o_hour      = r_fields.hour;

endmodule : fnd_source_scheduler
`default_nettype wire

// File: tb/tb_fnd_source_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_source_scheduler
// Brief    : Directed self-checking bench with a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fnd_source_scheduler;

  localparam int HOLD = 3;
  localparam int PAGE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_tick = 0, i_btn_src = 0, i_btn_page = 0, i_auto_en = 0;
  logic       i_req_valid = 0, i_req_src = 0;
  logic [6:0] i_sw_msec = 0, i_sw_sec = 0, i_sw_min = 0, i_sw_hour = 0;
  logic [6:0] i_wt_msec = 0, i_wt_sec = 0, i_wt_min = 0, i_wt_hour = 0;
  logic       i_sw_upd = 0, i_wt_upd = 0;
  logic       o_req_ready, o_time_mode, o_src, o_override;
  logic [6:0] o_msec, o_sec, o_min, o_hour;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  fnd_source_scheduler #(.HOLD_TICKS(HOLD), .PAGE_TICKS(PAGE)) dut (
    .clk(clk), .reset(reset), .i_tick(i_tick), .i_btn_src(i_btn_src),
    .i_btn_page(i_btn_page), .i_auto_en(i_auto_en), .i_req_valid(i_req_valid),
    .i_req_src(i_req_src), .o_req_ready(o_req_ready),
    .i_sw_msec(i_sw_msec), .i_sw_sec(i_sw_sec), .i_sw_min(i_sw_min), .i_sw_hour(i_sw_hour),
    .i_sw_upd(i_sw_upd),
    .i_wt_msec(i_wt_msec), .i_wt_sec(i_wt_sec), .i_wt_min(i_wt_min), .i_wt_hour(i_wt_hour),
    .i_wt_upd(i_wt_upd),
    .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
    .o_time_mode(o_time_mode), .o_src(o_src), .o_override(o_override)
  );

  always #5 clk = ~clk;

  // Model: what the display must show, derived directly from the rules.
  bit m_in_ovr, m_ovr_src, m_base, m_src, m_page, m_ready;
  int m_hold, m_pcnt;
  int m_f[4];

  task automatic model_reset();
    m_in_ovr = 0; m_ovr_src = 0; m_base = 0; m_src = 0; m_page = 0; m_ready = 0;
    m_hold = 0; m_pcnt = 0;
    for (int k = 0; k < 4; k++) m_f[k] = 0;
  endtask

  task automatic model_step();
    bit accepted, wrap, shown, upd;
    accepted = !m_in_ovr && m_ready && i_req_valid;
    if (accepted) begin
      m_in_ovr = 1; m_ovr_src = i_req_src; m_hold = HOLD;
    end else if (m_in_ovr && i_tick) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) m_in_ovr = 0;
    end
    m_base = m_base ^ i_btn_src;
    shown  = m_in_ovr ? m_ovr_src : m_base;
    upd    = shown ? i_wt_upd : i_sw_upd;
    wrap   = i_auto_en && i_tick && (m_pcnt == PAGE - 1);
    if (shown != m_src || upd) begin
      if (shown) begin
        m_f[0] = i_wt_msec; m_f[1] = i_wt_sec; m_f[2] = i_wt_min; m_f[3] = i_wt_hour;
      end else begin
        m_f[0] = i_sw_msec; m_f[1] = i_sw_sec; m_f[2] = i_sw_min; m_f[3] = i_sw_hour;
      end
    end
    if (shown != m_src) begin
      m_page = 0; m_pcnt = 0;
    end else begin
      if (i_btn_page || wrap) m_page = !m_page;
      if (!i_auto_en || i_btn_page || wrap) m_pcnt = 0;
      else if (i_tick) m_pcnt = m_pcnt + 1;
    end
    m_src   = shown;
    m_ready = !m_in_ovr;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready",    32'(o_req_ready), 32'(m_ready));
      chk("m_override", 32'(o_override),  32'(m_in_ovr));
      chk("m_src",      32'(o_src),       32'(m_src));
      chk("m_mode",     32'(o_time_mode), 32'(m_page));
      chk("m_msec",     32'(o_msec),      32'(m_f[0]));
      chk("m_sec",      32'(o_sec),       32'(m_f[1]));
      chk("m_min",      32'(o_min),       32'(m_f[2]));
      chk("m_hour",     32'(o_hour),      32'(m_f[3]));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick();
    i_tick = 1; step(); i_tick = 0; step();
  endtask

  initial begin
    repeat (2) step();
    chk_en = 1;
    step();
    chk("rst_ready", 32'(o_req_ready), 0);
    chk("rst_msec",  32'(o_msec), 0);
    reset = 1;
    step();
    chk("ready_after_release", 32'(o_req_ready), 1);

    i_sw_msec = 12; i_sw_sec = 34; i_sw_min = 56; i_sw_hour = 7; i_sw_upd = 1;
    step(); i_sw_upd = 0;
    chk("sw_msec", 32'(o_msec), 12); chk("sw_sec", 32'(o_sec), 34);
    chk("sw_min", 32'(o_min), 56);   chk("sw_hour", 32'(o_hour), 7);
    chk("sw_src", 32'(o_src), 0);

    i_wt_msec = 1; i_wt_sec = 2; i_wt_min = 3; i_wt_hour = 4; i_wt_upd = 1;
    step(); i_wt_upd = 0;
    chk("wt_upd_ignored", 32'(o_msec), 12);

    i_btn_page = 1; step(); i_btn_page = 0;
    chk("page_btn", 32'(o_time_mode), 1);
    i_btn_src = 1; step(); i_btn_src = 0;
    chk("src_to_wt", 32'(o_src), 1);
    chk("wt_fields", 32'(o_msec), 1);
    chk("wt_hour", 32'(o_hour), 4);
    chk("page_forced", 32'(o_time_mode), 0);
    i_btn_src = 1; step(); i_btn_src = 0;
    chk("src_back_sw", 32'(o_msec), 12);

    // Override to WT; keep valid high afterwards as a second (SW) request.
    i_req_valid = 1; i_req_src = 1; step(); i_req_src = 0;
    chk("ovr_on", 32'(o_override), 1); chk("ovr_ready", 32'(o_req_ready), 0);
    chk("ovr_src", 32'(o_src), 1);
    tick(); tick();
    chk("ovr_still", 32'(o_override), 1);
    i_tick = 1; step(); i_tick = 0;
    chk("ovr_end", 32'(o_override), 0); chk("ovr_end_src", 32'(o_src), 0);
    chk("ovr_end_ready", 32'(o_req_ready), 1);
    step(); i_req_valid = 0;
    chk("second_accept", 32'(o_override), 1);
    for (int n = 0; n < HOLD; n++) tick();
    chk("second_done", 32'(o_override), 0);

    // Auto scroll every PAGE ticks; page press coincident with wrap toggles once.
    i_auto_en = 1;
    for (int n = 0; n < PAGE; n++) tick();
    chk("auto_wrap1", 32'(o_time_mode), 1);
    for (int n = 0; n < PAGE - 1; n++) tick();
    i_tick = 1; i_btn_page = 1; step(); i_tick = 0; i_btn_page = 0; step();
    chk("wrap_and_btn", 32'(o_time_mode), 0);
    for (int n = 0; n < PAGE - 1; n++) tick();
    chk("cnt_cleared", 32'(o_time_mode), 0);
    tick();
    chk("auto_wrap2", 32'(o_time_mode), 1);
    i_auto_en = 0;

    // Base toggle together with an accepted SW override.
    i_btn_src = 1; i_req_valid = 1; i_req_src = 0; step();
    i_btn_src = 0; i_req_valid = 0;
    chk("same_clk_ovr", 32'(o_override), 1); chk("same_clk_src", 32'(o_src), 0);
    for (int n = 0; n < HOLD; n++) tick();
    chk("expiry_src", 32'(o_src), 1); chk("expiry_msec", 32'(o_msec), 1);

    // Reset asserted mid-override with two ticks of hold left.
    i_req_valid = 1; i_req_src = 0; step(); i_req_valid = 0;
    chk("ovr2_src", 32'(o_src), 0);
    tick();
    #2 reset = 0;
    #1;
    chk("async_ovr", 32'(o_override), 0); chk("async_msec", 32'(o_msec), 0);
    chk("async_ready", 32'(o_req_ready), 0); chk("async_src", 32'(o_src), 0);
    step();
    reset = 1;
    step();
    chk("rel_ready", 32'(o_req_ready), 1); chk("rel_ovr", 32'(o_override), 0);
    step();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fnd_source_scheduler
`default_nettype wire
